// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light phase scheduler.
package tl_pkg;

   localparam int DWELL_W = 8;

   typedef enum logic [2:0] {
      MAIN_GREEN  = 3'd0,
      MAIN_YELLOW = 3'd1,
      ALLRED_A    = 3'd2,
      SIDE_GREEN  = 3'd3,
      SIDE_YELLOW = 3'd4,
      WALK        = 3'd5,
      ALLRED_B    = 3'd6,
      FLASH       = 3'd7
   } phase_e;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   // A zero dwell would never expire cleanly, so it is promoted to one tick.
   function automatic logic [DWELL_W-1:0] dwell_eff(input int unsigned d);
      return (d == 0) ? DWELL_W'(1) : DWELL_W'(d);
   endfunction

endpackage

// File: rtl/tl_tick_timer.sv
// Tick prescaler plus saturating per-phase dwell counter; restart clears both.
module tl_tick_timer
   import tl_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               restart,
   output logic               tick,
   output logic [DWELL_W-1:0] count
);

   localparam int unsigned DIV  = (TICK_DIV == 0) ? 1 : TICK_DIV;
   localparam int          PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   logic [PW-1:0]      r_presc;
   logic [DWELL_W-1:0] r_count;
   logic               w_tick;

   assign w_tick = (r_presc == PMAX);
   assign tick   = w_tick;
   assign count  = r_count;

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         r_presc <= '0;
         r_count <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
         if (r_count != '1)
            r_count <= r_count + 1'b1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

endmodule

// File: rtl/tl_phase_scheduler.sv
// Main/side junction phase sequencer with pedestrian walk phase.
// Optional night flashing mode is enabled with `define NIGHT_FLASH_EN.
//
// state       | meaning
// MAIN_GREEN  | main road green, holds until expired and demand present
// MAIN_YELLOW | main road yellow
// ALLRED_A    | clearance, then WALK if pedestrian pending else SIDE_GREEN
// SIDE_GREEN  | side road green
// SIDE_YELLOW | side road yellow
// WALK        | both red, walk lamp lit
// ALLRED_B    | clearance before main green (reset state)
// FLASH       | night mode: main flashes yellow, side flashes red
module tl_phase_scheduler
   import tl_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 50000000,
   parameter int unsigned MAIN_GREEN_T = 30,
   parameter int unsigned SIDE_GREEN_T = 15,
   parameter int unsigned YELLOW_T     = 4,
   parameter int unsigned ALLRED_T     = 2,
   parameter int unsigned WALK_T       = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req,
   input  logic       side_sensor,
`ifdef NIGHT_FLASH_EN
   input  logic       night_mode,
`endif
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   localparam logic [DWELL_W-1:0] MG_D = dwell_eff(MAIN_GREEN_T);
   localparam logic [DWELL_W-1:0] SG_D = dwell_eff(SIDE_GREEN_T);
   localparam logic [DWELL_W-1:0] Y_D  = dwell_eff(YELLOW_T);
   localparam logic [DWELL_W-1:0] AR_D = dwell_eff(ALLRED_T);
   localparam logic [DWELL_W-1:0] W_D  = dwell_eff(WALK_T);

   phase_e             r_state;
   phase_e             w_next;
   logic               r_ped_prev;
   logic               r_ped_pending;
   logic [2:0]         r_main;
   logic [2:0]         r_side;
   logic               r_walk;
   logic               r_ack;
   logic               w_tick;
   logic [DWELL_W-1:0] w_count;
   logic [DWELL_W-1:0] w_dur;
   logic               w_expired;
   logic               w_restart;
   logic               w_walk_entry;
   logic               w_ped_edge;
   logic [2:0]         w_main_nx;
   logic [2:0]         w_side_nx;
   logic               w_walk_nx;
`ifdef NIGHT_FLASH_EN
   logic               r_flash_on;
   logic               w_flash_on_nx;
`endif

   tl_tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (w_restart),
      .tick    (w_tick),
      .count   (w_count)
   );

   always_comb begin
      w_dur = AR_D;
      case (r_state)
         MAIN_GREEN:  w_dur = MG_D;
         MAIN_YELLOW: w_dur = Y_D;
         ALLRED_A:    w_dur = AR_D;
         SIDE_GREEN:  w_dur = SG_D;
         SIDE_YELLOW: w_dur = Y_D;
         WALK:        w_dur = W_D;
         ALLRED_B:    w_dur = AR_D;
         FLASH:       w_dur = AR_D;
      endcase
   end

   // Expiry also fires on the tick that brings the count up to the dwell, so a
   // phase of D ticks lasts exactly D*TICK_DIV cycles.
   assign w_expired = ({1'b0, w_count} >= {1'b0, w_dur}) ||
                      (w_tick && (({1'b0, w_count} + 9'd1) >= {1'b0, w_dur}));

   always_comb begin
      w_next = r_state;
      case (r_state)
         MAIN_GREEN:  if (w_expired && (r_ped_pending || side_sensor)) w_next = MAIN_YELLOW;
         MAIN_YELLOW: if (w_expired) w_next = ALLRED_A;
         ALLRED_A:    if (w_expired) w_next = r_ped_pending ? WALK : SIDE_GREEN;
         SIDE_GREEN:  if (w_expired) w_next = SIDE_YELLOW;
         SIDE_YELLOW: if (w_expired) w_next = ALLRED_B;
         WALK:        if (w_expired) w_next = ALLRED_B;
         ALLRED_B:    if (w_expired) w_next = MAIN_GREEN;
         FLASH:       w_next = ALLRED_B;
      endcase
`ifdef NIGHT_FLASH_EN
      if (night_mode)
         w_next = FLASH;
`endif
   end

   assign w_restart    = (w_next != r_state);
   assign w_walk_entry = (w_next == WALK) && (r_state != WALK);
   assign w_ped_edge   = ped_req && !r_ped_prev;

`ifdef NIGHT_FLASH_EN
   assign w_flash_on_nx = (r_state != FLASH) ? 1'b1 : (w_tick ? !r_flash_on : r_flash_on);
`endif

   // Lamps are decoded from the next state so they change with the phase code.
   always_comb begin
      w_main_nx = LAMP_RED;
      w_side_nx = LAMP_RED;
      w_walk_nx = 1'b0;
      case (w_next)
         MAIN_GREEN:  w_main_nx = LAMP_GRN;
         MAIN_YELLOW: w_main_nx = LAMP_YEL;
         SIDE_GREEN:  w_side_nx = LAMP_GRN;
         SIDE_YELLOW: w_side_nx = LAMP_YEL;
         WALK:        w_walk_nx = 1'b1;
`ifdef NIGHT_FLASH_EN
         FLASH: begin
            w_main_nx = w_flash_on_nx ? LAMP_YEL : LAMP_OFF;
            w_side_nx = w_flash_on_nx ? LAMP_RED : LAMP_OFF;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ALLRED_B;
         r_ped_prev    <= ped_req;
         r_ped_pending <= 1'b0;
         r_main        <= LAMP_RED;
         r_side        <= LAMP_RED;
         r_walk        <= 1'b0;
         r_ack         <= 1'b0;
`ifdef NIGHT_FLASH_EN
         r_flash_on    <= 1'b1;
`endif
      end else begin
         r_state    <= w_next;
         r_ped_prev <= ped_req;
         if (w_walk_entry)
            r_ped_pending <= 1'b0;
         else if (w_ped_edge && (r_state != WALK) && (r_state != FLASH))
            r_ped_pending <= 1'b1;
         r_main     <= w_main_nx;
         r_side     <= w_side_nx;
         r_walk     <= w_walk_nx;
         r_ack      <= w_walk_entry;
`ifdef NIGHT_FLASH_EN
         r_flash_on <= w_flash_on_nx;
`endif
      end
   end

   assign main_light = r_main;
   assign side_light = r_side;
   assign walk       = r_walk;
   assign ped_ack    = r_ack;
   assign phase      = r_state;

endmodule
